// File: rtl/seq_rr_if.sv
// Handshake bundle between per-channel bit sources and the shared sequence engine.
// The requester side drives req/x/clr; the scheduler answers with ack and the output beat.
interface seq_rr_if #(
    parameter int NCH = 4
) ();
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0] req;
    logic [NCH-1:0] x;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] ack;
    logic           y_valid;
    logic           y;
    logic [CW-1:0]  y_ch;
    logic [1:0]     y_ab;

    modport master (output req, x, clr, input ack, y_valid, y, y_ch, y_ab);
    modport slave  (input req, x, clr, output ack, y_valid, y, y_ch, y_ab);
endinterface

// File: rtl/seq_rr_scheduler.sv
// One 2-bit Mealy engine (A,B; Y = A&X) shared across NCH bit-stream channels.
// Round-robin arbitration with burst hold; each channel keeps its own saved {A,B} context.

module seq_ctx_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       clr,
    input  logic       x,
    output logic [1:0] nab,
    output logic       ny
);
    logic [1:0] ab;

    // 11 is unreachable in normal operation and behaves as S0
    always_comb begin
        nab = 2'b00;
        ny  = 1'b0;
        if (x) begin
            case (ab)
                2'b00:   nab = 2'b01;
                2'b01:   nab = 2'b10;
                2'b10:   begin nab = 2'b00; ny = 1'b1; end
                default: nab = 2'b01;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)      ab <= 2'b00;
        else if (clr)  ab <= 2'b00;
        else if (step) ab <= nab;
    end
endmodule

module seq_rr_scheduler #(
    parameter  int NCH   = 4,
    parameter  int BURST = 2,
    localparam int CW    = $clog2(NCH)
) (
    input logic     clk,
    input logic     rst,
    seq_rr_if.slave bus
);
    localparam int CNTW = $clog2(BURST + 1);

    logic [CW-1:0]   ptr;
    logic [CW-1:0]   owner;
    logic            own_vld;
    logic [CNTW-1:0] cnt;

    logic            hold;
    logic            found;
    logic [CW-1:0]   pick;
    logic            gnt_vld;
    logic [CW-1:0]   gnt;
    logic [NCH-1:0]  gnt_oh;
    int              idx;

    logic [NCH-1:0][1:0] lane_nab;
    logic [NCH-1:0]      lane_y;

    // Burst hold first; otherwise first requester at or after ptr, wrapping
    always_comb begin
        hold  = own_vld && bus.req[owner] && (cnt < CNTW'(BURST));
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
        gnt_vld = rst && (hold || found);
        gnt     = hold ? owner : pick;
        gnt_oh  = '0;
        if (gnt_vld) gnt_oh[gnt] = 1'b1;
    end

    assign bus.ack = gnt_oh;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= '0;
            owner   <= '0;
            own_vld <= 1'b0;
            cnt     <= '0;
        end else if (hold) begin
            cnt <= cnt + 1'b1;
        end else if (found) begin
            owner   <= pick;
            own_vld <= 1'b1;
            cnt     <= CNTW'(1);
            ptr     <= (pick == CW'(NCH - 1)) ? '0 : pick + 1'b1;
        end else begin
            own_vld <= 1'b0;
            cnt     <= '0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        seq_ctx_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .step (gnt_oh[i]),
            .clr  (bus.clr[i]),
            .x    (bus.x[i]),
            .nab  (lane_nab[i]),
            .ny   (lane_y[i])
        );
    end

    // clr on the granted channel still consumes the bit but reports a cleared result
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.y_valid <= 1'b0;
            bus.y       <= 1'b0;
            bus.y_ch    <= '0;
            bus.y_ab    <= 2'b00;
        end else begin
            bus.y_valid <= gnt_vld;
            if (gnt_vld) begin
                bus.y    <= bus.clr[gnt] ? 1'b0 : lane_y[gnt];
                bus.y_ch <= gnt;
                bus.y_ab <= bus.clr[gnt] ? 2'b00 : lane_nab[gnt];
            end
        end
    end
endmodule

// File: tb/tb_seq_rr_scheduler.sv
// Directed-vector bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_seq_rr_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    typedef struct {
        int         due;
        logic       y;
        logic [1:0] ch;
        logic [1:0] ab;
    } exp_t;
    exp_t sbq[$];

    seq_rr_if #(.NCH(4)) bus ();

    seq_rr_scheduler #(.NCH(4), .BURST(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Monitor: every valid beat must match the oldest expected beat, on the expected cycle
    always @(negedge clk) begin
        exp_t e;
        if (bus.y_valid === 1'b1) begin
            checks = checks + 1;
            if (sbq.size() == 0) begin
                failures = failures + 1;
                $display("FAIL beat_unexpected cyc=%0d got y=%b ch=%0d ab=%b", cyc, bus.y, bus.y_ch, bus.y_ab);
            end else begin
                e = sbq.pop_front();
                if (bus.y !== e.y || bus.y_ch !== e.ch || bus.y_ab !== e.ab || cyc != e.due) begin
                    failures = failures + 1;
                    $display("FAIL beat cyc=%0d got y=%b ch=%0d ab=%b, want y=%b ch=%0d ab=%b at cyc=%0d",
                             cyc, bus.y, bus.y_ch, bus.y_ab, e.y, e.ch, e.ab, e.due);
                end
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            checks   = checks + 1;
            failures = failures + 1;
            e = sbq.pop_front();
            $display("FAIL beat_missing cyc=%0d got y_valid=%b, want ch=%0d due=%0d", cyc, bus.y_valid, e.ch, e.due);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h want=%0h", name, act, expv);
        end
    endtask

    // One cycle: drive inputs, check combinational ack, queue the expected beat
    task automatic beat(input logic [3:0] rq, input logic [3:0] xv, input logic [3:0] cl,
                        input logic [3:0] eack, input logic ey, input logic [1:0] eab);
        exp_t e;
        bus.req = rq;
        bus.x   = xv;
        bus.clr = cl;
        #1;
        chk("ack", 32'(bus.ack), 32'(eack));
        if (eack != 4'b0000) begin
            e.due = cyc + 1;
            e.y   = ey;
            e.ab  = eab;
            e.ch  = 2'b00;
            for (int i = 0; i < 4; i++) if (eack[i]) e.ch = 2'(i);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'b00);
    endtask

    initial begin
        rst     = 1'b0;
        bus.req = '0;
        bus.x   = '0;
        bus.clr = '0;
        @(posedge clk);
        #1;

        // Reset: all requesting, nothing granted, outputs zero
        beat(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'b00);
        beat(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'b00);
        chk("reset_y_valid", 32'(bus.y_valid), 32'd0);
        chk("reset_y_ab", 32'(bus.y_ab), 32'd0);
        rst = 1'b1;
        beat(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00);
        beat(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'b00);
        beat(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'b00);
        beat(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'b00);
        idle();

        // Single channel 0, x=1 for six beats (ptr=0)
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b01);
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b10);
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'b00);
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b01);
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b10);
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'b00);
        // ptr is 1 here; a grant to ch3 brings it back to 0
        beat(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'b00);
        idle();

        // Fairness, BURST=2: 0,0,1,1,2,2,3,3,0,0
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00);
        beat(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'b00);
        idle();

        // Context isolation: ch1 to S2, ch2 three beats, ch1 resumes from S2
        beat(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'b01);
        beat(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'b10);
        beat(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'b01);
        beat(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'b10);
        beat(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'b00);
        beat(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'b00);
        idle();
        chk("idle_y_valid", 32'(bus.y_valid), 32'd0);
        chk("idle_hold_y", 32'(bus.y), 32'd1);
        chk("idle_hold_y_ch", 32'(bus.y_ch), 32'd1);

        // clr on the granted channel wins; context really is cleared afterwards
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b01);
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b10);
        beat(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'b00);
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b01);
        idle();

        // Mid-burst drop: ch2 owns for one beat, then ch3 takes over the same cycle
        beat(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'b01);
        beat(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'b01);
        beat(4'b1100, 4'b1111, 4'b0000, 4'b1000, 1'b0, 2'b10);
        // Mid-stream reset: no grant, outputs zero on the next cycle
        rst = 1'b0;
        beat(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'b00);
        chk("rst_y_valid", 32'(bus.y_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_y_ch", 32'(bus.y_ch), 32'd0);
        chk("rst_y_ab", 32'(bus.y_ab), 32'd0);
        rst = 1'b1;
        // Every context back at S0: x=1 gives 01
        beat(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'b01);
        beat(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'b01);
        beat(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'b01);
        beat(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 2'b01);
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
